steel_timer_responder: RTL and testbench
========================================

# steel_timer_responder

Memory-mapped machine timer that sits on the Steel core's data bus as a responder and sources the core's `REAL_TIME` and `T_IRQ` inputs. It decodes `D_ADDR`/`WR_REQ`/`WR_MASK`/`DATA_OUT` and returns read data on `DATA_IN`. It keeps a 64-bit `mtime` counter with a programmable prescaler and a 64-bit `mtimecmp`, and raises the timer interrupt on compare. It is instantiated beside `steel_top` and data memory in the SoC top; a bus mux selects its `DATA_IN` on address hit.

## Interface
- `BASE_ADDR`, default 32'h8000_0000: register window base; must be 32-byte aligned.
- `CLK`  input  1  system clock, rising edge.
- `RESET`  input  1  reset, synchronous, active-high.
- `D_ADDR`  input  32  data address from core.
- `DATA_OUT`  input  32  write data from core.
- `WR_REQ`  input  1  write strobe, one cycle per store.
- `WR_MASK`  input  4  byte-lane enables; bit n covers `DATA_OUT[8n+7:8n]`.
- `DATA_IN`  output  32  registered read data to core.
- `HIT`  output  1  registered; high when the returned `DATA_IN` came from this window, for the SoC read mux.
- `REAL_TIME`  output  64  current `mtime`.
- `T_IRQ`  output  1  registered timer interrupt.

## Operation
- Window hit: `D_ADDR[31:5] == BASE_ADDR[31:5]`. Word select is `D_ADDR[4:2]`; `D_ADDR[1:0]` is ignored.
- Register map, word offsets:
  - 0x00 MTIME_LO, rw.
  - 0x04 MTIME_HI, rw; reads return the shadow.
  - 0x08 MTIMECMP_LO, rw.
  - 0x0C MTIMECMP_HI, rw.
  - 0x10 CTRL, rw: bit0 EN (count enable), bit1 IE (irq enable); other bits read 0.
  - 0x14 PRESCALE, rw, 32 bits.
  - 0x18 and 0x1C: read 0, writes ignored.
- Writes: when `WR_REQ`=1 and hit, each register is byte-merged under `WR_MASK`. A miss is ignored.
- Reads: no read strobe. Every cycle, `DATA_IN` is loaded with the addressed register on a hit, or 0 on a miss. `HIT` is loaded with the hit flag.
- Tear-free read of `mtime`: any hit on MTIME_LO with `WR_REQ`=0 copies `mtime[63:32]` into SHADOW_HI in the same edge. A MTIME_HI read returns SHADOW_HI.
- Prescaler:
  - PCNT (32 bits) counts up while EN=1.
  - When PCNT == PRESCALE, PCNT returns to 0 and `mtime` increments by 1.
  - PRESCALE=0 gives an increment every cycle.
  - EN=0 holds both PCNT and `mtime`.
- `mtime` wraps from 2^64−1 to 0 with no flag.
- Simultaneous software write and increment to `mtime`: the write wins for the written bytes. Unwritten bytes keep their pre-increment value; there is no increment that cycle. A PRESCALE write resets PCNT to 0.
- Interrupt:
  - `T_IRQ` is updated every edge to IE & (`mtime` >= `mtimecmp`), evaluated on current register values.
  - The comparison is unsigned 64-bit.
  - Level-sensitive; cleared only by raising `mtimecmp`, lowering `mtime`, or clearing IE.
- `REAL_TIME` is `mtime` directly, with no extra register stage.

## Timing
- Reset values: `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESCALE=0, PCNT=0, SHADOW_HI=0, `DATA_IN`=0, `HIT`=0, `T_IRQ`=0, `REAL_TIME`=0.
- Reset asserted mid-operation overrides any write or increment in that cycle.
- Read latency is 1 cycle: address at edge k produces `DATA_IN` valid after edge k+1 and stable for that cycle.
- Write latency: the register updates at the edge sampling `WR_REQ`. A read of the same word in the next cycle returns the new value.
- `T_IRQ` lags the compare condition by 1 cycle. If `mtime` reaches `mtimecmp` at edge k, `T_IRQ` rises at edge k+1.
- The first increment after EN is set occurs PRESCALE+1 cycles after the CTRL write edge.

## Structure
- Shared package `steel_timer_pkg`:
  - Word-offset constants: `TMR_MTIME_LO`, `TMR_MTIME_HI`, `TMR_MTIMECMP_LO`, `TMR_MTIMECMP_HI`, `TMR_CTRL`, `TMR_PRESCALE`.
  - CTRL bit indices `TMR_CTRL_EN`, `TMR_CTRL_IE`.
  - Reset value of `mtimecmp`.
- One sub-module: `steel_byte_merge`, combinational; takes old 32-bit word, new word and 4-bit mask and returns the merged word. It is reused for all six registers.

## Test plan
- Reset, then read all offsets 0x00–0x1C: `DATA_IN`=0 everywhere except MTIMECMP_LO/HI = 0xFFFF_FFFF; `T_IRQ`=0; `HIT`=1 on each.
- Write PRESCALE=3, CTRL=1, then wait 40 cycles: `REAL_TIME` increments by 1 every 4 cycles and reads 10 after 40 cycles.
- Write MTIME_LO=0xFFFF_FFFE, MTIME_HI=0, PRESCALE=0, EN=1: after 2 increments `REAL_TIME`=64'h1_0000_0000. Reading LO then HI returns a consistent pair (HI from the shadow).
- Write MTIMECMP=20, CTRL=3 with `mtime` counting from 0: `T_IRQ` rises exactly 1 cycle after `REAL_TIME`=20. Writing MTIMECMP_HI=1 drops `T_IRQ` 1 cycle after the write edge.
- Byte write: MTIMECMP_LO=0x1122_3344 followed by write 0xAABB_CCDD with `WR_MASK`=4'b0101 reads back 0x11BB_33DD.
- Out-of-window: `D_ADDR`=BASE+0x20 with `WR_REQ`=1 leaves all registers unchanged; `DATA_IN`=0 and `HIT`=0.
- Assert `RESET` for 1 cycle while counting with `T_IRQ`=1: all outputs return to reset values at that edge.

Source files
------------

// File: rtl/steel_timer_pkg.sv
// Shared constants for the Steel memory-mapped machine timer:
// register word offsets, CTRL bit positions and the mtimecmp reset value.
package steel_timer_pkg;

  localparam logic [2:0] TMR_MTIME_LO    = 3'd0;
  localparam logic [2:0] TMR_MTIME_HI    = 3'd1;
  localparam logic [2:0] TMR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] TMR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] TMR_CTRL        = 3'd4;
  localparam logic [2:0] TMR_PRESCALE    = 3'd5;

  localparam int TMR_CTRL_EN = 0;
  localparam int TMR_CTRL_IE = 1;

  localparam logic [31:0] TMR_CTRL_IMPL_MASK = 32'h0000_0003;
  localparam logic [63:0] TMR_MTIMECMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/steel_byte_merge.sv
// Combinational byte-lane merge: each lane whose mask bit is set takes the
// new byte, every other lane keeps the old one.
module steel_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  mask,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/steel_timer_responder.sv
// Machine timer responder on the Steel data bus: 64-bit mtime with prescaler,
// 64-bit mtimecmp, level timer interrupt and a tear-free MTIME_HI shadow.
module steel_timer_responder
  import steel_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] DATA_OUT,
  input  logic        WR_REQ,
  input  logic [3:0]  WR_MASK,
  output logic [31:0] DATA_IN,
  output logic        HIT,
  output logic [63:0] REAL_TIME,
  output logic        T_IRQ
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] ctrl;
  logic [31:0] prescale;
  logic [31:0] pcnt;
  logic [31:0] shadow_hi;

  logic        hit;
  logic [2:0]  word;
  logic        wr;
  logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_pre;
  logic        en, ie, tick;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  logic [31:0] m_mtime_lo, m_mtime_hi, m_cmp_lo, m_cmp_hi, m_ctrl, m_pre;

  assign hit  = (D_ADDR[31:5] == BASE_ADDR[31:5]);
  assign word = D_ADDR[4:2];
  assign wr   = WR_REQ && hit;
  assign unused_addr_bits = ^D_ADDR[1:0];

  assign wr_mtime_lo = wr && (word == TMR_MTIME_LO);
  assign wr_mtime_hi = wr && (word == TMR_MTIME_HI);
  assign wr_cmp_lo   = wr && (word == TMR_MTIMECMP_LO);
  assign wr_cmp_hi   = wr && (word == TMR_MTIMECMP_HI);
  assign wr_ctrl     = wr && (word == TMR_CTRL);
  assign wr_pre      = wr && (word == TMR_PRESCALE);

  assign en   = ctrl[TMR_CTRL_EN];
  assign ie   = ctrl[TMR_CTRL_IE];
  assign tick = en && (pcnt == prescale);

  assign REAL_TIME = mtime;

  steel_byte_merge u_merge_mtime_lo (.old_word(mtime[31:0]),     .new_word(DATA_OUT), .mask(WR_MASK), .merged(m_mtime_lo));
  steel_byte_merge u_merge_mtime_hi (.old_word(mtime[63:32]),    .new_word(DATA_OUT), .mask(WR_MASK), .merged(m_mtime_hi));
  steel_byte_merge u_merge_cmp_lo   (.old_word(mtimecmp[31:0]),  .new_word(DATA_OUT), .mask(WR_MASK), .merged(m_cmp_lo));
  steel_byte_merge u_merge_cmp_hi   (.old_word(mtimecmp[63:32]), .new_word(DATA_OUT), .mask(WR_MASK), .merged(m_cmp_hi));
  steel_byte_merge u_merge_ctrl     (.old_word(ctrl),            .new_word(DATA_OUT), .mask(WR_MASK), .merged(m_ctrl));
  steel_byte_merge u_merge_pre      (.old_word(prescale),        .new_word(DATA_OUT), .mask(WR_MASK), .merged(m_pre));

  // MTIME_HI reads come from the shadow so a LO-then-HI pair never tears.
  always_comb begin
    rd_word = 32'd0;
    case (word)
      TMR_MTIME_LO:    rd_word = mtime[31:0];
      TMR_MTIME_HI:    rd_word = shadow_hi;
      TMR_MTIMECMP_LO: rd_word = mtimecmp[31:0];
      TMR_MTIMECMP_HI: rd_word = mtimecmp[63:32];
      TMR_CTRL:        rd_word = ctrl;
      TMR_PRESCALE:    rd_word = prescale;
      default:         rd_word = 32'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mtime     <= 64'd0;
      mtimecmp  <= TMR_MTIMECMP_RST;
      ctrl      <= 32'd0;
      prescale  <= 32'd0;
      pcnt      <= 32'd0;
      shadow_hi <= 32'd0;
      DATA_IN   <= 32'd0;
      HIT       <= 1'b0;
      T_IRQ     <= 1'b0;
    end else begin
      // A software write to either mtime half suppresses that cycle's increment.
      if (wr_mtime_lo)      mtime <= {mtime[63:32], m_mtime_lo};
      else if (wr_mtime_hi) mtime <= {m_mtime_hi, mtime[31:0]};
      else if (tick)        mtime <= mtime + 64'd1;

      if (wr_cmp_lo) mtimecmp[31:0]  <= m_cmp_lo;
      if (wr_cmp_hi) mtimecmp[63:32] <= m_cmp_hi;
      if (wr_ctrl)   ctrl <= m_ctrl & TMR_CTRL_IMPL_MASK;

      if (wr_pre) begin
        prescale <= m_pre;
        pcnt     <= 32'd0;
      end else if (en) begin
        pcnt <= tick ? 32'd0 : pcnt + 32'd1;
      end

      if (hit && !WR_REQ && (word == TMR_MTIME_LO)) shadow_hi <= mtime[63:32];

      DATA_IN <= hit ? rd_word : 32'd0;
      HIT     <= hit;
      T_IRQ   <= ie && (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_steel_timer_responder.sv
// Directed bench for steel_timer_responder: register map, prescaler, wrap and
// shadow, interrupt, byte lanes, window decode and mid-run reset.
module tb_steel_timer_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] IDLE = 32'h0000_1000;
  localparam logic [4:0] O_MLO = 5'h00, O_MHI = 5'h04, O_CLO = 5'h08, O_CHI = 5'h0C,
                         O_CTRL = 5'h10, O_PRE = 5'h14, O_R18 = 5'h18;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] D_ADDR;
  logic [31:0] DATA_OUT;
  logic        WR_REQ;
  logic [3:0]  WR_MASK;
  logic [31:0] DATA_IN;
  logic        HIT;
  logic [63:0] REAL_TIME;
  logic        T_IRQ;

  int n_cmp = 0;
  int n_bad = 0;

  steel_timer_responder #(.BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RESET(RESET), .D_ADDR(D_ADDR), .DATA_OUT(DATA_OUT),
    .WR_REQ(WR_REQ), .WR_MASK(WR_MASK), .DATA_IN(DATA_IN), .HIT(HIT),
    .REAL_TIME(REAL_TIME), .T_IRQ(T_IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] m);
    D_ADDR = BASE + {27'd0, off};
    DATA_OUT = d;
    WR_MASK = m;
    WR_REQ = 1'b1;
    tick();
    WR_REQ = 1'b0;
    WR_MASK = 4'h0;
    D_ADDR = IDLE;
  endtask

  task automatic bus_rd(input logic [4:0] off, output logic [31:0] d);
    D_ADDR = BASE + {27'd0, off};
    WR_REQ = 1'b0;
    tick();
    d = DATA_IN;
    D_ADDR = IDLE;
  endtask

  task automatic test_reset();
    logic [31:0] d, exp;
    logic [4:0] off;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    n_cmp++; if (T_IRQ !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", T_IRQ); end
    n_cmp++; if (REAL_TIME !== 64'd0) begin n_bad++; $display("FAIL reset_time got %h want 0", REAL_TIME); end
    n_cmp++; if (HIT !== 1'b0) begin n_bad++; $display("FAIL reset_hit got %b want 0", HIT); end
    n_cmp++; if (DATA_IN !== 32'd0) begin n_bad++; $display("FAIL reset_data got %h want 0", DATA_IN); end
    for (int i = 0; i < 8; i++) begin
      off = 5'(i * 4);
      exp = (i == 2 || i == 3) ? 32'hFFFF_FFFF : 32'd0;
      bus_rd(off, d);
      n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL reset_read[%0h] got %h want %h", off, d, exp); end
      n_cmp++; if (HIT !== 1'b1) begin n_bad++; $display("FAIL reset_hit[%0h] got %b want 1", off, HIT); end
    end
  endtask

  task automatic test_prescale();
    bus_wr(O_PRE, 32'd3, 4'hF);
    bus_wr(O_CTRL, 32'd1, 4'hF);
    for (int i = 1; i <= 40; i++) begin
      tick();
      n_cmp++;
      if (REAL_TIME !== 64'(i / 4)) begin
        n_bad++; $display("FAIL prescale_time[%0d] got %0d want %0d", i, REAL_TIME, i / 4);
      end
    end
    bus_wr(O_CTRL, 32'd0, 4'hF);
    n_cmp++; if (REAL_TIME !== 64'd10) begin n_bad++; $display("FAIL prescale_hold got %0d want 10", REAL_TIME); end
  endtask

  task automatic test_wrap_shadow();
    logic [31:0] lo, hi;
    bus_wr(O_PRE, 32'd0, 4'hF);
    bus_wr(O_MLO, 32'hFFFF_FFFE, 4'hF);
    bus_wr(O_MHI, 32'd0, 4'hF);
    bus_wr(O_CTRL, 32'd1, 4'hF);
    D_ADDR = BASE + {27'd0, O_MLO}; tick(); lo = DATA_IN;
    D_ADDR = BASE + {27'd0, O_MHI}; tick(); hi = DATA_IN;
    D_ADDR = IDLE;
    n_cmp++; if (REAL_TIME !== 64'h1_0000_0000) begin n_bad++; $display("FAIL wrap_time got %h want 100000000", REAL_TIME); end
    n_cmp++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFFE) begin n_bad++; $display("FAIL wrap_pair got %h want 00000000fffffffe", {hi, lo}); end
    bus_wr(O_CTRL, 32'd0, 4'hF);
    // carry into HI between the LO and HI reads: HI must still be the old value
    bus_wr(O_MLO, 32'hFFFF_FFFF, 4'hF);
    bus_wr(O_MHI, 32'd5, 4'hF);
    bus_wr(O_CTRL, 32'd1, 4'hF);
    D_ADDR = BASE + {27'd0, O_MLO}; tick(); lo = DATA_IN;
    D_ADDR = BASE + {27'd0, O_MHI}; tick(); hi = DATA_IN;
    D_ADDR = IDLE;
    n_cmp++; if ({hi, lo} !== 64'h0000_0005_FFFF_FFFF) begin n_bad++; $display("FAIL shadow_pair got %h want 00000005ffffffff", {hi, lo}); end
    n_cmp++; if (REAL_TIME !== 64'h6_0000_0001) begin n_bad++; $display("FAIL shadow_time got %h want 600000001", REAL_TIME); end
    bus_wr(O_CTRL, 32'd0, 4'hF);
  endtask

  task automatic test_irq();
    bus_wr(O_MLO, 32'd0, 4'hF);
    bus_wr(O_MHI, 32'd0, 4'hF);
    bus_wr(O_CLO, 32'd20, 4'hF);
    bus_wr(O_CHI, 32'd0, 4'hF);
    bus_wr(O_CTRL, 32'd3, 4'hF);
    n_cmp++; if (T_IRQ !== 1'b0) begin n_bad++; $display("FAIL irq_start got %b want 0", T_IRQ); end
    for (int n = 1; n <= 25; n++) begin
      tick();
      n_cmp++; if (REAL_TIME !== 64'(n)) begin n_bad++; $display("FAIL irq_time[%0d] got %0d want %0d", n, REAL_TIME, n); end
      n_cmp++; if (T_IRQ !== (n >= 21)) begin n_bad++; $display("FAIL irq_level[%0d] got %b want %b", n, T_IRQ, n >= 21); end
    end
    bus_wr(O_CHI, 32'd1, 4'hF);
    n_cmp++; if (T_IRQ !== 1'b1) begin n_bad++; $display("FAIL irq_at_cmp_write got %b want 1", T_IRQ); end
    tick();
    n_cmp++; if (T_IRQ !== 1'b0) begin n_bad++; $display("FAIL irq_cleared got %b want 0", T_IRQ); end
    bus_wr(O_CTRL, 32'd0, 4'hF);
  endtask

  task automatic test_byte_write();
    logic [31:0] d;
    bus_wr(O_CLO, 32'h1122_3344, 4'hF);
    bus_wr(O_CLO, 32'hAABB_CCDD, 4'b0101);
    bus_rd(O_CLO, d);
    n_cmp++; if (d !== 32'h11BB_33DD) begin n_bad++; $display("FAIL byte_merge got %h want 11bb33dd", d); end
    bus_wr(O_CTRL, 32'hFFFF_FFFC, 4'hF);
    bus_rd(O_CTRL, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL ctrl_reserved got %h want 0", d); end
  endtask

  task automatic test_out_of_window();
    logic [31:0] d;
    bus_wr(O_MLO, 32'h55, 4'hF);
    bus_wr(O_MHI, 32'd0, 4'hF);
    D_ADDR = BASE + 32'h20; DATA_OUT = 32'h1234_5678; WR_MASK = 4'hF; WR_REQ = 1'b1;
    tick();
    n_cmp++; if (DATA_IN !== 32'd0) begin n_bad++; $display("FAIL oow_data got %h want 0", DATA_IN); end
    n_cmp++; if (HIT !== 1'b0) begin n_bad++; $display("FAIL oow_hit got %b want 0", HIT); end
    D_ADDR = BASE + 32'h34; tick();
    D_ADDR = BASE ^ 32'h4000_0000; tick();
    WR_REQ = 1'b0; WR_MASK = 4'h0; D_ADDR = IDLE;
    bus_rd(O_MLO, d);
    n_cmp++; if (d !== 32'h55) begin n_bad++; $display("FAIL oow_mtime got %h want 55", d); end
    bus_rd(O_PRE, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL oow_prescale got %h want 0", d); end
    bus_wr(O_R18, 32'hFFFF_FFFF, 4'hF);
    bus_rd(O_R18, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reserved_18 got %h want 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_wr(O_CHI, 32'd0, 4'hF);
    bus_wr(O_CLO, 32'h10, 4'hF);
    bus_wr(O_CTRL, 32'd3, 4'hF);
    D_ADDR = BASE + {27'd0, O_CLO}; tick();
    n_cmp++; if (T_IRQ !== 1'b1) begin n_bad++; $display("FAIL mid_pre_irq got %b want 1", T_IRQ); end
    n_cmp++; if (REAL_TIME !== 64'h56) begin n_bad++; $display("FAIL mid_pre_time got %h want 56", REAL_TIME); end
    RESET = 1'b1; WR_REQ = 1'b1; D_ADDR = BASE; DATA_OUT = 32'hABCD; WR_MASK = 4'hF;
    tick();
    RESET = 1'b0; WR_REQ = 1'b0; WR_MASK = 4'h0; D_ADDR = IDLE;
    n_cmp++; if (REAL_TIME !== 64'd0) begin n_bad++; $display("FAIL mid_time got %h want 0", REAL_TIME); end
    n_cmp++; if (T_IRQ !== 1'b0) begin n_bad++; $display("FAIL mid_irq got %b want 0", T_IRQ); end
    n_cmp++; if (HIT !== 1'b0) begin n_bad++; $display("FAIL mid_hit got %b want 0", HIT); end
    n_cmp++; if (DATA_IN !== 32'd0) begin n_bad++; $display("FAIL mid_data got %h want 0", DATA_IN); end
    tick(); tick(); tick();
    n_cmp++; if (REAL_TIME !== 64'd0) begin n_bad++; $display("FAIL mid_stopped got %h want 0", REAL_TIME); end
    bus_rd(O_CLO, d);
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mid_cmp_lo got %h want ffffffff", d); end
    bus_rd(O_CTRL, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL mid_ctrl got %h want 0", d); end
  endtask

  initial begin
    RESET = 1'b1;
    WR_REQ = 1'b0;
    WR_MASK = 4'h0;
    D_ADDR = IDLE;
    DATA_OUT = 32'd0;
    test_reset();
    test_prescale();
    test_wrap_shadow();
    test_irq();
    test_byte_write();
    test_out_of_window();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
